// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - IF-stage PC generator with in-flight branch prediction FIFO
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          QDEPTH        = 4,
    parameter bit          USE_PRED_DEST = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        fetch_ready_i,
    output logic [31:0] pc_o,
    output logic        fetch_valid_o,
    input  logic        dec_branch_i,
    input  logic [31:0] dec_target_i,
    input  logic        pred_take_i,
    input  logic [31:0] pred_dest_i,
    input  logic        ex_resolve_i,
    input  logic        ex_taken_i,
    input  logic [31:0] ex_target_i,
    output logic        flush_o,
    output logic        fb_valid_o,
    output logic [31:0] fb_pc_o,
    output logic        fb_taken_o,
    output logic [31:0] fb_dest_o,
    output logic        q_full_o,
    output logic        resolve_err_o
);

    localparam int AW = $clog2(QDEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(QDEPTH);

    logic [31:0] q_pc    [QDEPTH];
    logic [31:0] q_pnext [QDEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic        acc;
    logic        push;
    logic        pop;
    logic        mispredict;
    logic [31:0] tgt;
    logic [31:0] pnext;
    logic [31:0] head_pc;
    logic [31:0] head_pnext;
    logic [31:0] anext;

    assign q_full_o      = (count == FULL_CNT);
    assign fetch_valid_o = !q_full_o;
    assign acc           = fetch_valid_o & fetch_ready_i & !stall_i;

    assign tgt   = USE_PRED_DEST ? pred_dest_i : dec_target_i;
    assign pnext = (dec_branch_i & pred_take_i) ? tgt : pc_o + 32'd4;
    assign push  = acc & dec_branch_i;

    assign head_pc    = q_pc[rd_ptr];
    assign head_pnext = q_pnext[rd_ptr];
    assign pop        = ex_resolve_i & (count != '0);
    assign anext      = ex_taken_i ? ex_target_i : head_pc + 32'd4;
    // The prediction is judged on the resulting next PC, not on the taken bit alone.
    assign mispredict = pop & (anext != head_pnext);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_o          <= RESET_PC;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            flush_o       <= 1'b0;
            fb_valid_o    <= 1'b0;
            fb_pc_o       <= '0;
            fb_taken_o    <= 1'b0;
            fb_dest_o     <= '0;
            resolve_err_o <= 1'b0;
        end else begin
            fb_valid_o <= pop;
            if (pop) begin
                fb_pc_o    <= head_pc;
                fb_taken_o <= ex_taken_i;
                fb_dest_o  <= ex_target_i;
            end
            if (ex_resolve_i && count == '0) begin
                resolve_err_o <= 1'b1;
            end

            if (mispredict) begin
                // Redirect wins: drop this cycle's fetch and every younger prediction.
                pc_o    <= anext;
                flush_o <= 1'b1;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
            end else begin
                flush_o <= 1'b0;
                if (acc) begin
                    pc_o <= pnext;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !push) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !mispredict && push) begin
            q_pc[wr_ptr]    <= pc_o;
            q_pnext[wr_ptr] <= pnext;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        fetch_ready_i;
    logic [31:0] pc_o;
    logic        fetch_valid_o;
    logic        dec_branch_i;
    logic [31:0] dec_target_i;
    logic        pred_take_i;
    logic [31:0] pred_dest_i;
    logic        ex_resolve_i;
    logic        ex_taken_i;
    logic [31:0] ex_target_i;
    logic        flush_o;
    logic        fb_valid_o;
    logic [31:0] fb_pc_o;
    logic        fb_taken_o;
    logic [31:0] fb_dest_o;
    logic        q_full_o;
    logic        resolve_err_o;

    int checks   = 0;
    int failures = 0;

    fetch_pc_unit #(
        .RESET_PC     (32'h0000_0000),
        .QDEPTH       (4),
        .USE_PRED_DEST(1'b0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .fetch_ready_i(fetch_ready_i),
        .pc_o         (pc_o),
        .fetch_valid_o(fetch_valid_o),
        .dec_branch_i (dec_branch_i),
        .dec_target_i (dec_target_i),
        .pred_take_i  (pred_take_i),
        .pred_dest_i  (pred_dest_i),
        .ex_resolve_i (ex_resolve_i),
        .ex_taken_i   (ex_taken_i),
        .ex_target_i  (ex_target_i),
        .flush_o      (flush_o),
        .fb_valid_o   (fb_valid_o),
        .fb_pc_o      (fb_pc_o),
        .fb_taken_o   (fb_taken_o),
        .fb_dest_o    (fb_dest_o),
        .q_full_o     (q_full_o),
        .resolve_err_o(resolve_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic branch(input logic take, input logic [31:0] target);
        dec_branch_i = 1'b1;
        pred_take_i  = take;
        dec_target_i = target;
    endtask

    task automatic no_branch();
        dec_branch_i = 1'b0;
        pred_take_i  = 1'b0;
        dec_target_i = 32'h0;
    endtask

    task automatic resolve(input logic taken, input logic [31:0] target);
        ex_resolve_i = 1'b1;
        ex_taken_i   = taken;
        ex_target_i  = target;
    endtask

    initial begin
        rst = 1'b1; stall_i = 1'b0; fetch_ready_i = 1'b0;
        dec_branch_i = 1'b0; dec_target_i = '0; pred_take_i = 1'b0;
        pred_dest_i = 32'hDEAD_0000;
        ex_resolve_i = 1'b0; ex_taken_i = 1'b0; ex_target_i = '0;

        // T1 reset and sequential fetch
        step(); step();
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_flush", {31'b0, flush_o}, 32'h0);
        chk("rst_fbv", {31'b0, fb_valid_o}, 32'h0);
        chk("rst_fbpc", fb_pc_o, 32'h0);
        chk("rst_fbdest", fb_dest_o, 32'h0);
        chk("rst_err", {31'b0, resolve_err_o}, 32'h0);
        chk("rst_fv", {31'b0, fetch_valid_o}, 32'h1);
        rst = 1'b0; fetch_ready_i = 1'b1;
        step(); chk("t1_pc4", pc_o, 32'h4);
        step(); chk("t1_pc8", pc_o, 32'h8);
        step(); chk("t1_pc12", pc_o, 32'hC);
        chk("t1_flush", {31'b0, flush_o}, 32'h0);
        step(); chk("t1_pc16", pc_o, 32'h10);

        // T2 predicted-taken branch at 0x10, resolved as a hit
        branch(1'b1, 32'h40);
        step(); chk("t2_pc_tgt", pc_o, 32'h40);
        no_branch(); resolve(1'b1, 32'h40);
        step();
        chk("t2_fbv", {31'b0, fb_valid_o}, 32'h1);
        chk("t2_fbpc", fb_pc_o, 32'h10);
        chk("t2_fbtaken", {31'b0, fb_taken_o}, 32'h1);
        chk("t2_fbdest", fb_dest_o, 32'h40);
        chk("t2_flush", {31'b0, flush_o}, 32'h0);
        chk("t2_pc", pc_o, 32'h44);
        ex_resolve_i = 1'b0;
        step();
        chk("t2_fbv_off", {31'b0, fb_valid_o}, 32'h0);
        chk("t2_fbpc_hold", fb_pc_o, 32'h10);
        chk("t2_pc2", pc_o, 32'h48);

        // T3 predicted not-taken at 0x48, actually taken to 0x80
        branch(1'b0, 32'h60);
        step(); chk("t3_pc_fall", pc_o, 32'h4C);
        branch(1'b1, 32'h100); resolve(1'b1, 32'h80);
        step();
        chk("t3_pc_redir", pc_o, 32'h80);
        chk("t3_flush", {31'b0, flush_o}, 32'h1);
        chk("t3_fbpc", fb_pc_o, 32'h48);
        chk("t3_fbtaken", {31'b0, fb_taken_o}, 32'h1);
        no_branch(); ex_resolve_i = 1'b0;
        step();
        chk("t3_flush_off", {31'b0, flush_o}, 32'h0);
        chk("t3_pc_next", pc_o, 32'h84);
        // FIFO must be empty: the discarded same-cycle branch was not pushed
        resolve(1'b0, 32'h0);
        step();
        chk("t6_err", {31'b0, resolve_err_o}, 32'h1);
        chk("t6_fbv", {31'b0, fb_valid_o}, 32'h0);
        chk("t6_pc", pc_o, 32'h88);
        ex_resolve_i = 1'b0;

        // T4 fill the FIFO with four not-taken branches
        branch(1'b0, 32'h500);
        step(); step(); step();
        chk("t4_not_full3", {31'b0, q_full_o}, 32'h0);
        step();
        chk("t4_full", {31'b0, q_full_o}, 32'h1);
        chk("t4_fv", {31'b0, fetch_valid_o}, 32'h0);
        chk("t4_pc", pc_o, 32'h98);
        step();
        chk("t4_pc_hold", pc_o, 32'h98);
        resolve(1'b0, 32'h0);
        step();
        chk("t4_fv_back", {31'b0, fetch_valid_o}, 32'h1);
        chk("t4_fbpc", fb_pc_o, 32'h88);
        chk("t4_flush", {31'b0, flush_o}, 32'h0);
        chk("t4_pc_still", pc_o, 32'h98);

        // T5 push 0x98 while popping 0x8C, then drain in order
        step();
        chk("t5_fbpc0", fb_pc_o, 32'h8C);
        chk("t5_pc", pc_o, 32'h9C);
        chk("t5_nfull", {31'b0, q_full_o}, 32'h0);
        no_branch();
        step(); chk("t5_fbpc1", fb_pc_o, 32'h90);
        step(); chk("t5_fbpc2", fb_pc_o, 32'h94);
        resolve(1'b1, 32'h9C);
        step();
        chk("t5_fbpc3", fb_pc_o, 32'h98);
        chk("t5_flush", {31'b0, flush_o}, 32'h0);
        chk("t5_pc_end", pc_o, 32'hA8);
        ex_resolve_i = 1'b0;

        // Mispredict to the top of the address space, then PC wrap
        branch(1'b0, 32'h0);
        step(); chk("w_pc", pc_o, 32'hAC);
        no_branch(); resolve(1'b1, 32'hFFFF_FFFC);
        step();
        chk("w_redir", pc_o, 32'hFFFF_FFFC);
        chk("w_flush", {31'b0, flush_o}, 32'h1);
        ex_resolve_i = 1'b0;
        step(); chk("w_wrap", pc_o, 32'h0);

        // Stall holds PC and blocks pushes
        stall_i = 1'b1; branch(1'b1, 32'h200);
        step(); chk("st_pc1", pc_o, 32'h0);
        step(); chk("st_pc2", pc_o, 32'h0);
        step(); chk("st_pc3", pc_o, 32'h0);
        stall_i = 1'b0; no_branch();
        step(); chk("st_pc4", pc_o, 32'h4);
        branch(1'b0, 32'h0);
        step();
        no_branch(); resolve(1'b0, 32'h0);
        step();
        chk("st_head", fb_pc_o, 32'h4);
        chk("st_flush", {31'b0, flush_o}, 32'h0);
        ex_resolve_i = 1'b0;

        // Reset mid-stream with an entry in flight
        branch(1'b1, 32'h300);
        step(); chk("mr_pc", pc_o, 32'h300);
        no_branch(); rst = 1'b1;
        step();
        chk("mr_rst_pc", pc_o, 32'h0);
        chk("mr_rst_err", {31'b0, resolve_err_o}, 32'h0);
        chk("mr_rst_fbpc", fb_pc_o, 32'h0);
        rst = 1'b0; resolve(1'b1, 32'h40);
        step();
        chk("mr_empty_err", {31'b0, resolve_err_o}, 32'h1);
        chk("mr_empty_fbv", {31'b0, fb_valid_o}, 32'h0);
        chk("mr_pc_next", pc_o, 32'h4);
        ex_resolve_i = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
